// File: rtl/sea_state_sampler_pkg.sv
// sea_state_sampler_pkg: shared data width, quadrature direction encoding and 32-bit saturation.
package sea_state_sampler_pkg;

    localparam int DW = 32;

    // Encoding equals the modulo-4 step between the previous and current Gray-decoded phases
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_FWD  = 2'd1,
        DIR_ERR  = 2'd2,
        DIR_REV  = 2'd3
    } dir_t;

    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    function automatic dir_t quad_dir(input logic [1:0] prv, input logic [1:0] cur);
        return dir_t'(gray2bin(prv) - gray2bin(cur));
    endfunction

    function automatic logic signed [DW-1:0] sat32(input logic signed [63:0] v);
        return v > 64'sd2147483647 ? 32'sh7FFFFFFF :
               v < -64'sd2147483648 ? 32'sh80000000 : v[DW-1:0];
    endfunction

endpackage

// File: rtl/sea_state_sampler_quad_decoder.sv
// quad_decoder: encoder pin synchroniser, 4x decode, wrapping position count and illegal-transition counter.
module quad_decoder
    import sea_state_sampler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 pos_clr,
    output logic signed [DW-1:0] count,
    output logic                 enc_err,
    output logic [15:0]          err_cnt
);

    logic [1:0] s1, s2, d;
    dir_t       dir;

    always_comb dir = quad_dir(d, s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            d       <= '0;
            count   <= '0;
            enc_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            s1      <= {enc_a, enc_b};
            s2      <= s1;
            d       <= s2;
            count   <= pos_clr ? '0 :
                       dir == DIR_FWD ? count + 32'sd1 :
                       dir == DIR_REV ? count - 32'sd1 : count;
            enc_err <= dir == DIR_ERR;
            err_cnt <= (dir == DIR_ERR && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
        end
    end

endmodule

// File: rtl/sea_state_sampler.sv
// sea_state_sampler: sample timer, two-stage theta/dtheta pipeline with saturated velocity.
// Define SEA_VEL_FILTER_EN for a 4-tap moving-sum velocity filter.
module sea_state_sampler
    import sea_state_sampler_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int VEL_SHIFT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 pos_clr,
    output logic signed [DW-1:0] theta,
    output logic signed [DW-1:0] dtheta,
    output logic                 out_valid,
    output logic                 enc_err,
    output logic [15:0]          err_cnt
);

    localparam int TW = $clog2(SAMPLE_DIV);

    logic [TW-1:0]        timer;
    logic                 tick, stage2;
    logic signed [DW-1:0] count, prev, diff, theta_s;
    logic signed [63:0]   vel;

    quad_decoder u_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .pos_clr (pos_clr),
        .count   (count),
        .enc_err (enc_err),
        .err_cnt (err_cnt)
    );

    assign tick = en && timer == TW'(SAMPLE_DIV - 1);

`ifdef SEA_VEL_FILTER_EN
    logic signed [DW-1:0] hist [3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hist <= '{default: '0};
        else if (pos_clr)
            hist <= '{default: '0};
        else if (tick)
            hist <= '{diff, hist[0], hist[1]};
    end

    // Divisor stays 4 while history fills, so early samples read low
    always_comb vel = ((64'(diff) + 64'(hist[0]) + 64'(hist[1]) + 64'(hist[2])) <<< VEL_SHIFT) >>> 2;
`else
    always_comb vel = 64'(diff) <<< VEL_SHIFT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            prev      <= '0;
            diff      <= '0;
            theta_s   <= '0;
            stage2    <= 1'b0;
            theta     <= '0;
            dtheta    <= '0;
            out_valid <= 1'b0;
        end else begin
            timer     <= (!en || tick) ? '0 : timer + 1'b1;
            // A tick coincident with pos_clr still samples the pre-clear count
            prev      <= pos_clr ? '0 : tick ? count : prev;
            diff      <= tick ? count - prev : pos_clr ? '0 : diff;
            theta_s   <= tick ? count : theta_s;
            stage2    <= tick;
            theta     <= stage2 ? theta_s : theta;
            dtheta    <= stage2 ? sat32(vel) : dtheta;
            out_valid <= stage2;
        end
    end

endmodule

// File: tb/tb_sea_state_sampler.sv
// tb_sea_state_sampler: directed vector bench, SAMPLE_DIV=8 with VEL_SHIFT=4 and a VEL_SHIFT=30 saturation instance.
module tb_sea_state_sampler;

`ifdef SEA_VEL_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        int          steps;
        logic [31:0] th;
        logic [31:0] d;
        logic [31:0] ds;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, enc_a = 1'b0, enc_b = 1'b0, pos_clr = 1'b0;
    logic [31:0] theta, dtheta, theta2, dtheta2;
    logic        out_valid, out_valid2, enc_err, enc_err2;
    logic [15:0] err_cnt, err_cnt2;
    int          n_cmp = 0, n_bad = 0, nv = 0, ne = 0, ne2 = 0, phase = 0;
    logic [1:0]  pat [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    vec_t        v [7];

    sea_state_sampler #(.SAMPLE_DIV(8), .VEL_SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .enc_a(enc_a), .enc_b(enc_b), .pos_clr(pos_clr),
        .theta(theta), .dtheta(dtheta), .out_valid(out_valid), .enc_err(enc_err), .err_cnt(err_cnt)
    );

    sea_state_sampler #(.SAMPLE_DIV(8), .VEL_SHIFT(30)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .enc_a(enc_a), .enc_b(enc_b), .pos_clr(pos_clr),
        .theta(theta2), .dtheta(dtheta2), .out_valid(out_valid2), .enc_err(enc_err2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) nv++;
        if (enc_err) ne++;
        if (enc_err2) ne2++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic move(input int n);
        for (int i = 0; i < (n < 0 ? -n : n); i++) begin
            phase = (phase + (n < 0 ? 3 : 1)) % 4;
            {enc_a, enc_b} = pat[phase];
            @(negedge clk);
        end
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 40);
        chk("strobe", {31'd0, out_valid}, 32'd1);
        chk("strobe_sat", {31'd0, out_valid2}, 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [31:0] th, input logic [31:0] d, input logic [31:0] ds);
        chk($sformatf("%s theta", tag), theta, th);
        chk($sformatf("%s dtheta", tag), dtheta, d);
        chk($sformatf("%s theta_sat", tag), theta2, th);
        chk($sformatf("%s dtheta_sat", tag), dtheta2, ds);
    endtask

    initial begin
        int cyc, base;
        v[0] = '{ 3, 32'h3,        FILT ? 32'hC        : 32'h30,       FILT ? 32'h30000000 : 32'h7FFFFFFF};
        v[1] = '{ 2, 32'h5,        FILT ? 32'h14       : 32'h20,       FILT ? 32'h50000000 : 32'h7FFFFFFF};
        v[2] = '{-3, 32'h2,        FILT ? 32'h8        : 32'hFFFFFFD0, FILT ? 32'h20000000 : 32'h80000000};
        v[3] = '{-2, 32'h0,        FILT ? 32'h0        : 32'hFFFFFFE0, FILT ? 32'h0        : 32'h80000000};
        v[4] = '{-2, 32'hFFFFFFFE, FILT ? 32'hFFFFFFEC : 32'hFFFFFFE0, FILT ? 32'hB0000000 : 32'h80000000};
        v[5] = '{ 0, 32'hFFFFFFFE, FILT ? 32'hFFFFFFE4 : 32'h0,        FILT ? 32'h90000000 : 32'h0};
        v[6] = '{ 1, 32'hFFFFFFFF, FILT ? 32'hFFFFFFF4 : 32'h10,       FILT ? 32'hD0000000 : 32'h40000000};
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst theta", theta, 32'h0);
        chk("rst dtheta", dtheta, 32'h0);
        chk("rst out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst enc_err", {31'd0, enc_err}, 32'h0);
        chk("rst err_cnt", {16'd0, err_cnt}, 32'h0);
        en = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            move(v[i].steps);
            wait_strobe(cyc);
            check_out($sformatf("row%0d", i), v[i].th, v[i].d, v[i].ds);
        end
        #1 chk("strobe_count", nv, 7);
        // Both pins flip at once
        phase = (phase + 2) % 4;
        {enc_a, enc_b} = pat[phase];
        repeat (4) @(negedge clk);
        chk("enc_err_pulses", ne, 1);
        chk("enc_err_pulses_sat", ne2, 1);
        chk("err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("err_cnt_sat", {16'd0, err_cnt2}, 32'd1);
        wait_strobe(cyc);
        check_out("illegal", 32'hFFFFFFFF, FILT ? 32'hFFFFFFFC : 32'h0, FILT ? 32'hF0000000 : 32'h0);
        // Clear lands on the same edge as the decoded +1
        move(1);
        @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        wait_strobe(cyc);
        check_out("clr_edge", 32'h0, 32'h0, 32'h0);
        // Clear coincident with the tick edge
        move(1);
        repeat (5) @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        wait_strobe(cyc);
        check_out("clr_tick_a", 32'h1, FILT ? 32'h4 : 32'h10, FILT ? 32'h10000000 : 32'h40000000);
        wait_strobe(cyc);
        check_out("clr_tick_b", 32'h0, FILT ? 32'h4 : 32'h0, FILT ? 32'h10000000 : 32'h0);
        // Asynchronous reset mid-period
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async theta", theta, 32'h0);
        chk("async dtheta", dtheta, 32'h0);
        chk("async out_valid", {31'd0, out_valid}, 32'h0);
        chk("async enc_err", {31'd0, enc_err}, 32'h0);
        chk("async err_cnt", {16'd0, err_cnt}, 32'h0);
        {enc_a, enc_b} = 2'b00;
        phase = 0;
        @(negedge clk);
        rst_n = 1'b1;
        move(-2);
        wait_strobe(cyc);
        chk("rst_latency", cyc + 2, 9);
        check_out("rev_reset", 32'hFFFFFFFE, FILT ? 32'hFFFFFFF8 : 32'hFFFFFFE0, FILT ? 32'hE0000000 : 32'h80000000);
        wait_strobe(cyc);
        check_out("still", 32'hFFFFFFFE, FILT ? 32'hFFFFFFF8 : 32'h0, FILT ? 32'hE0000000 : 32'h0);
        // Timer disabled
        en = 1'b0;
        #1 base = nv;
        repeat (20) @(negedge clk);
        #1 chk("en_off", nv, base);
        en = 1'b1;
        wait_strobe(cyc);
        chk("en_latency", cyc, 9);
        check_out("en_resume", 32'hFFFFFFFE, FILT ? 32'hFFFFFFF8 : 32'h0, FILT ? 32'hE0000000 : 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
